// File: rtl/console_pkg.sv
// Shared types and constants for the text console writer: FSM states,
// control-code values and the frame-buffer address packing.
package console_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        SCR_RD,
        SCR_WR,
        SCR_CLR,
        CLR
    } state_t;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    function automatic logic [12:0] pack_adrs(input logic [6:0] x, input logic [5:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/raster_walker.sv
// Raster-order (x,y) cell counter shared by scroll copy, scroll fill and clear.
// Rows start at a loadable value and end at a fixed last row.
module raster_walker #(
    parameter int H_SIZE   = 80,
    parameter int ROW_LAST = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [5:0] load_y,
    input  logic       step,
    output logic [6:0] x,
    output logic [5:0] y,
    output logic       last
);

    localparam logic [6:0] X_LAST = 7'(H_SIZE - 1);
    localparam logic [5:0] Y_LAST = 6'(ROW_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= '0;
            y <= load_y;
        end else if (step) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= y + 6'd1;
            end else begin
                x <= x + 7'd1;
            end
        end
    end

    assign last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/text_console_writer.sv
// Character-stream terminal front end: cursor handling, control codes,
// hardware scroll-up and screen clear into port A of the text frame buffer.
module text_console_writer
    import console_pkg::*;
#(
    parameter int         H_SIZE         = 80,
    parameter int         V_SIZE         = 60,
    parameter logic [7:0] BLANK_CODE     = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [7:0]  in_char,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [12:0] fb_adrs,
    output logic [7:0]  fb_data,
    output logic        fb_we,
    input  logic [7:0]  fb_q,
    output logic [6:0]  cur_x,
    output logic [5:0]  cur_y,
    output logic        busy
);

    localparam logic [6:0] X_LAST = 7'(H_SIZE - 1);
    localparam logic [5:0] Y_LAST = 6'(V_SIZE - 1);

    state_t      state, state_n;
    logic [6:0]  cx_n;
    logic [5:0]  cy_n;
    logic        we_r, we_n;
    logic [12:0] adrs_r, adrs_n;
    logic [7:0]  data_r, data_n;

    logic        w_load, w_step, w_last;
    logic [5:0]  w_load_y;
    logic [6:0]  w_x;
    logic [5:0]  w_y;

    raster_walker #(
        .H_SIZE  (H_SIZE),
        .ROW_LAST(V_SIZE - 1)
    ) u_walker (
        .clk   (cpu_clk),
        .reset (reset),
        .load  (w_load),
        .load_y(w_load_y),
        .step  (w_step),
        .x     (w_x),
        .y     (w_y),
        .last  (w_last)
    );

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state  <= CLEAR_ON_RESET ? CLR : IDLE;
            cur_x  <= '0;
            cur_y  <= '0;
            we_r   <= 1'b0;
            adrs_r <= '0;
            data_r <= '0;
        end else begin
            state  <= state_n;
            cur_x  <= cx_n;
            cur_y  <= cy_n;
            we_r   <= we_n;
            adrs_r <= adrs_n;
            data_r <= data_n;
        end
    end

    // Glyph writes are registered at the accept edge; fill writes are
    // registered one cycle behind the walker, so a fill finishes in IDLE.
    always_comb begin
        state_n  = state;
        cx_n     = cur_x;
        cy_n     = cur_y;
        we_n     = 1'b0;
        adrs_n   = adrs_r;
        data_n   = data_r;
        w_load   = 1'b0;
        w_load_y = '0;
        w_step   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    case (in_char)
                        CC_CR: cx_n = '0;
                        CC_BS: begin
                            if (cur_x != '0) cx_n = cur_x - 7'd1;
                        end
                        CC_LF: begin
                            cx_n = '0;
                            if (cur_y != Y_LAST) begin
                                cy_n = cur_y + 6'd1;
                            end else begin
                                state_n  = SCR_RD;
                                w_load   = 1'b1;
                                w_load_y = 6'd1;
                            end
                        end
                        CC_FF: begin
                            cx_n    = '0;
                            cy_n    = '0;
                            state_n = CLR;
                            w_load  = 1'b1;
                        end
                        default: begin
                            state_n = PUT;
                            we_n    = 1'b1;
                            adrs_n  = pack_adrs(cur_x, cur_y);
                            data_n  = in_char;
                        end
                    endcase
                end
            end
            PUT: begin
                state_n = IDLE;
                if (cur_x != X_LAST) begin
                    cx_n = cur_x + 7'd1;
                end else begin
                    cx_n = '0;
                    if (cur_y != Y_LAST) begin
                        cy_n = cur_y + 6'd1;
                    end else begin
                        state_n  = SCR_RD;
                        w_load   = 1'b1;
                        w_load_y = 6'd1;
                    end
                end
            end
            SCR_RD: state_n = SCR_WR;
            SCR_WR: begin
                adrs_n = pack_adrs(w_x, w_y - 6'd1);
                data_n = fb_q;
                if (w_last) begin
                    state_n  = SCR_CLR;
                    w_load   = 1'b1;
                    w_load_y = Y_LAST;
                end else begin
                    state_n = SCR_RD;
                    w_step  = 1'b1;
                end
            end
            SCR_CLR, CLR: begin
                we_n   = 1'b1;
                adrs_n = pack_adrs(w_x, w_y);
                data_n = BLANK_CODE;
                if (w_last) state_n = IDLE;
                else        w_step  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Scroll copy drives the port straight from the walker so the read
    // data returning in SCR_WR can be written back in the same cycle.
    always_comb begin
        fb_we   = we_r;
        fb_adrs = adrs_r;
        fb_data = data_r;
        if (state == SCR_RD) begin
            fb_adrs = pack_adrs(w_x, w_y);
        end else if (state == SCR_WR) begin
            fb_we   = 1'b1;
            fb_adrs = pack_adrs(w_x, w_y - 6'd1);
            fb_data = fb_q;
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a synchronous-read frame
// buffer model and write counters.
module tb_text_console_writer;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic [7:0]  in_char;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] fb_adrs;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic [7:0]  fb_q;
    logic [6:0]  cur_x;
    logic [5:0]  cur_y;
    logic        busy;

    logic        fill_row1 = 1'b0;
    logic [7:0]  mem [0:8191];
    int          wr_count    = 0;
    int          blank_count = 0;
    int          bad_count   = 0;

    int checks = 0;
    int errors = 0;

    text_console_writer dut (
        .cpu_clk (cpu_clk),
        .reset   (reset),
        .in_char (in_char),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .fb_adrs (fb_adrs),
        .fb_data (fb_data),
        .fb_we   (fb_we),
        .fb_q    (fb_q),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .busy    (busy)
    );

    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) begin
        fb_q <= mem[fb_adrs];
        if (fill_row1) begin
            for (int i = 0; i < 80; i++) mem[{6'd1, 7'(i)}] <= 8'h31;
        end else if (fb_we === 1'b1) begin
            mem[fb_adrs] <= fb_data;
            wr_count     <= wr_count + 1;
            if (fb_data == 8'h20) blank_count <= blank_count + 1;
            if (fb_adrs[6:0] >= 7'd80 || fb_adrs[12:7] >= 6'd60) bad_count <= bad_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20000) begin
            @(negedge cpu_clk);
            n++;
        end
        if (n >= 20000) chk("send_ready_timeout", 32'(in_ready), 32'd1);
        in_char  = c;
        in_valid = 1'b1;
        @(negedge cpu_clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int start, output int n);
        n = start;
        while (busy === 1'b1 && n < 30000) begin
            @(negedge cpu_clk);
            n++;
        end
        if (n >= 30000) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int bad;
        int wr0;

        reset    = 1'b1;
        in_char  = 8'h00;
        in_valid = 1'b0;
        repeat (3) @(negedge cpu_clk);

        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_adrs", 32'(fb_adrs), 32'd0);
        chk("rst_fb_data", 32'(fb_data), 32'd0);
        chk("rst_cursor", {cur_y, cur_x}, 32'd0);

        // Power-on clear
        reset = 1'b0;
        wr0 = wr_count;
        wait_idle(0, n);
        repeat (2) @(negedge cpu_clk);
        chk("clr_writes", 32'(wr_count - wr0), 32'd4800);
        chk("clr_blanks", 32'(blank_count), 32'd4800);
        chk("clr_bad_adrs", 32'(bad_count), 32'd0);
        chk("clr_ready", 32'(in_ready), 32'd1);
        chk("clr_cursor", {cur_y, cur_x}, 32'd0);
        chk("clr_last_cell", 32'(mem[{6'd59, 7'd79}]), 32'h20);

        // Glyph at (0,0)
        wr0 = wr_count;
        send(8'h41);
        chk("put_we", 32'(fb_we), 32'd1);
        chk("put_adrs", 32'(fb_adrs), 32'd0);
        chk("put_data", 32'(fb_data), 32'h41);
        chk("put_ready_low", 32'(in_ready), 32'd0);
        @(negedge cpu_clk);
        chk("put_we_drop", 32'(fb_we), 32'd0);
        chk("put_cur_x", 32'(cur_x), 32'd1);
        chk("put_ready_back", 32'(in_ready), 32'd1);
        chk("put_one_write", 32'(wr_count - wr0), 32'd1);

        // Backspace, then backspace at column 0
        wr0 = wr_count;
        send(8'h08);
        chk("bs_cur_x", 32'(cur_x), 32'd0);
        send(8'h08);
        chk("bs_col0_cursor", {cur_y, cur_x}, 32'd0);
        chk("bs_ready", 32'(in_ready), 32'd1);
        chk("bs_no_write", 32'(wr_count - wr0), 32'd0);

        // CR at (17,3)
        for (int i = 0; i < 3; i++) send(8'h0A);
        chk("lf_cur_y", 32'(cur_y), 32'd3);
        for (int i = 0; i < 17; i++) send(8'h61);
        @(negedge cpu_clk);
        chk("pre_cr_cursor", {cur_y, cur_x}, {6'd3, 7'd17});
        send(8'h0D);
        chk("cr_cursor", {cur_y, cur_x}, {6'd3, 7'd0});
        chk("cr_ready", 32'(in_ready), 32'd1);

        // Wrapping glyph at (79,5)
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 79; i++) send(8'h78);
        @(negedge cpu_clk);
        chk("pre_wrap_cursor", {cur_y, cur_x}, {6'd5, 7'd79});
        send(8'h42);
        chk("wrap_adrs", 32'(fb_adrs), 32'h2CF);
        chk("wrap_data", 32'(fb_data), 32'h42);
        @(negedge cpu_clk);
        chk("wrap_cursor", {cur_y, cur_x}, {6'd6, 7'd0});
        chk("wrap_ready", 32'(in_ready), 32'd1);

        // Scroll from (10,59) with row 1 preloaded
        for (int i = 0; i < 53; i++) send(8'h0A);
        for (int i = 0; i < 10; i++) send(8'h7A);
        @(negedge cpu_clk);
        chk("pre_scroll_cursor", {cur_y, cur_x}, {6'd59, 7'd10});
        fill_row1 = 1'b1;
        @(negedge cpu_clk);
        fill_row1 = 1'b0;
        send(8'h0A);
        chk("scr_rd_we", 32'(fb_we), 32'd0);
        chk("scr_rd_adrs", 32'(fb_adrs), 32'h080);
        @(negedge cpu_clk);
        chk("scr_wr_we", 32'(fb_we), 32'd1);
        chk("scr_wr_adrs", 32'(fb_adrs), 32'h000);
        chk("scr_wr_data", 32'(fb_data), 32'h31);
        @(negedge cpu_clk);
        wait_idle(2, n);
        chk("scroll_cycles", 32'(n), 32'd9520);
        chk("scroll_cursor", {cur_y, cur_x}, {6'd59, 7'd0});
        repeat (2) @(negedge cpu_clk);
        bad = 0;
        for (int x = 0; x < 80; x++) if (mem[{6'd0, 7'(x)}] !== 8'h31) bad++;
        chk("row0_from_row1", 32'(bad), 32'd0);
        bad = 0;
        for (int x = 0; x < 80; x++) if (mem[{6'd59, 7'(x)}] !== 8'h20) bad++;
        chk("row59_blank", 32'(bad), 32'd0);
        bad = 0;
        for (int x = 0; x < 10; x++) if (mem[{6'd58, 7'(x)}] !== 8'h7A) bad++;
        chk("row58_from_row59", 32'(bad), 32'd0);
        chk("row58_x10", 32'(mem[{6'd58, 7'd10}]), 32'h20);
        chk("row4_x79", 32'(mem[{6'd4, 7'd79}]), 32'h42);
        chk("row5_x79", 32'(mem[{6'd5, 7'd79}]), 32'h20);
        chk("scroll_bad_adrs", 32'(bad_count), 32'd0);

        // Wrap on the last row starts a scroll; reset 100 cycles in
        for (int i = 0; i < 79; i++) send(8'h62);
        @(negedge cpu_clk);
        chk("last_row_cursor", {cur_y, cur_x}, {6'd59, 7'd79});
        send(8'h63);
        chk("last_put_adrs", 32'(fb_adrs), 32'h1DCF);
        @(negedge cpu_clk);
        chk("wrap_scroll_busy", 32'(busy), 32'd1);
        chk("wrap_scroll_adrs", 32'(fb_adrs), 32'h080);
        chk("wrap_scroll_cursor", {cur_y, cur_x}, {6'd59, 7'd0});
        repeat (99) @(negedge cpu_clk);
        chk("mid_scroll_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge cpu_clk);
        chk("abort_we", 32'(fb_we), 32'd0);
        chk("abort_cursor", {cur_y, cur_x}, 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd0);
        wr0 = wr_count;
        @(negedge cpu_clk);
        chk("abort_we_held", 32'(fb_we), 32'd0);
        chk("abort_no_write", 32'(wr_count - wr0), 32'd0);
        reset = 1'b0;
        wr0 = wr_count;
        wait_idle(0, n);
        repeat (2) @(negedge cpu_clk);
        chk("reclr_writes", 32'(wr_count - wr0), 32'd4800);
        chk("reclr_ready", 32'(in_ready), 32'd1);
        chk("reclr_cursor", {cur_y, cur_x}, 32'd0);
        chk("reclr_cell", 32'(mem[{6'd0, 7'd5}]), 32'h20);
        chk("reclr_bad_adrs", 32'(bad_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Character-stream terminal front end sitting directly upstream of the character display controller. Accepts one 8-bit character code at a time over a valid/ready handshake, maintains a text cursor, and writes codes into port A of the 80×60 frame buffer (13-bit address {Y[5:0], X[6:0]}). Interprets a small control-code set (CR, LF, BS, FF), performs hardware scroll-up by reading port A back, and optionally clears the screen after reset. Runs entirely in the CPU clock domain.

## Interface
- H_SIZE, 80: text columns; X range 0..H_SIZE-1, at most 128.
- V_SIZE, 60: text rows; Y range 0..V_SIZE-1, at most 64.
- BLANK_CODE, 8'h20: code written by clear and scroll-fill.
- CLEAR_ON_RESET, 1: 1 enters clear-screen immediately after reset.

- cpu_clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- in_char  in  8  character code from the CPU.
- in_valid  in  1  in_char valid.
- in_ready  out  1  block accepts in_char this cycle.
- fb_adrs  out  13  frame buffer port A address {y[5:0], x[6:0]}.
- fb_data  out  8  frame buffer port A write data.
- fb_we  out  1  frame buffer port A write enable.
- fb_q  in  8  frame buffer port A read data; valid the cycle after fb_adrs is presented with fb_we=0.
- cur_x  out  7  cursor column.
- cur_y  out  6  cursor row.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, PUT, SCR_RD, SCR_WR, SCR_CLR, CLR.
- Accept: in_valid & in_ready at a rising edge. in_ready = (state==IDLE). Outputs are driven only from registers; no combinational path from in_* to fb_*/cur_*.
- 0x0D (CR): cur_x←0 at the accept edge; stay IDLE.
- 0x08 (BS): if cur_x>0, cur_x←cur_x-1; otherwise no change. No write. Stay IDLE.
- 0x0A (LF): cur_x←0. If cur_y<V_SIZE-1, cur_y←cur_y+1 and stay IDLE; otherwise → SCR_RD with cur_y unchanged.
- 0x0C (FF): cursor←(0,0), → CLR.
- Any other code (0x00..0xFF) is a glyph: latch it, → PUT. PUT drives fb_we=1, fb_adrs={cur_y,cur_x}, fb_data=latched code for one cycle. Then advance: cur_x+1; if cur_x==H_SIZE-1, cur_x←0 and the cursor wraps to the next line under the LF rules, so that wrapping on the last row scrolls. Otherwise → IDLE.
- Scroll: walk source cells (x,y) for y=1..V_SIZE-1 and x=0..H_SIZE-1 in raster order.
  - SCR_RD: fb_adrs={y,x}, fb_we=0.
  - SCR_WR: fb_adrs={y-1,x}, fb_data=fb_q, fb_we=1.
  - After the last cell → SCR_CLR: write BLANK_CODE to row V_SIZE-1, x=0..H_SIZE-1, one cell per cycle, then → IDLE.
- CLR: write BLANK_CODE to every (x,y), x<H_SIZE, y<V_SIZE, raster order, one per cycle, then → IDLE. Columns H_SIZE..127 are never addressed.
- Outside write cycles: fb_we=0. fb_adrs/fb_data hold their last values (don't-care).

## Timing
- Reset values: state=CLR if CLEAR_ON_RESET else IDLE; cur_x=0, cur_y=0; fb_we=0, fb_adrs=0, fb_data=0; in_ready=!CLEAR_ON_RESET; busy=CLEAR_ON_RESET.
- Reset asserted mid-operation (PUT, scroll or clear) aborts at that edge. No further writes occur, and the state returns to the reset values above.
- Glyph: accepted at edge k; write occurs in cycle k+1; in_ready high again in cycle k+2 (non-wrapping case). Sustained throughput is 1 glyph per 2 cycles.
- CR, BS and non-scrolling LF: cursor updated at the accept edge; in_ready stays high (1 per cycle).
- Scroll duration: 2·H_SIZE·(V_SIZE-1)+H_SIZE cycles (9520 with the defaults). Clear duration: H_SIZE·V_SIZE cycles (4800).
- in_valid held while in_ready=0 is ignored. The character is not consumed until a later accept edge.

## Structure
- Package console_pkg: FSM state enum; code constants CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D; function packing (x,y) into the 13-bit address.
- Sub-module raster_walker: an (x,y) counter with load of start row, step enable, and a last-cell flag bounded by H_SIZE and a row limit. It is shared by scroll, scroll-fill and clear.

## Test plan
- CLEAR_ON_RESET=1, release reset → exactly 4800 writes of 0x20 covering x 0..79, y 0..59, then in_ready=1, cursor (0,0).
- Send 'A' (0x41) at (0,0) → one write of 0x41 at address 0; cur_x=1 two cycles after accept.
- Cursor at (79,5), send 0x42 → write at {5,79}; cursor becomes (0,6).
- Cursor at (10,59), memory model row 1 filled with 0x31, send LF → row 0 holds 0x31, row 59 holds 0x20, busy for 9520 cycles, cursor (0,59).
- BS at x=0 → no write, cursor unchanged; CR at (17,3) → (0,3) with in_ready held high.
- Assert reset 100 cycles into a scroll → fb_we=0 from the next cycle onward, cursor (0,0), followed by a fresh clear.
